serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial add/subtract sequencer around a single full_adder cell.
//  - Accepts a WIDTH-bit operand pair through a valid/ready handshake.
//  - Walks the operands LSB-first through the cell, one bit per clock, with a
//    registered carry between bits.
//  - Returns sum, carry-out and signed overflow through a second valid/ready
//    handshake.
//  Trades latency for area wherever one adder cell must serve a multi-bit
//  operation.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..64
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      synchronous reset, active-high
//  start_valid_i  in   1      operand pair and mode valid
//  start_ready_o  out  1      controller can accept (IDLE only)
//  a_i            in   WIDTH  operand A
//  b_i            in   WIDTH  operand B
//  cin_i          in   1      carry-in for add; ignored when sub_i=1
//  sub_i          in   1      1: A-B (B inverted, carry-in forced 1)
//  res_valid_o    out  1      result valid (DONE only)
//  res_ready_i    in   1      consumer accepts result
//  sum_o          out  WIDTH  result, stable while res_valid_o=1
//  cout_o         out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf_o          out  1      signed overflow = carry-into-MSB ^ carry-out-of-MSB
//  busy_o         out  1      1 in RUN or DONE
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset values: start_ready_o=1, res_valid_o=0, busy_o=0, sum_o=0, cout_o=0,
//    ovf_o=0, FSM=IDLE, bit counter=0, carry register=0.
//  - FSM states: IDLE, RUN, DONE. No other states; illegal encodings go to IDLE.
//  - IDLE:
//    - start_ready_o=1.
//    - On the edge where start_valid_i & start_ready_o: load A into a shift reg,
//      load B (or ~B when sub_i=1) into a shift reg.
//    - Load carry reg with cin_i (or 1 when sub_i=1), clear cnt, go to RUN.
//  - RUN:
//    - Each edge feeds a[0], b[0] and the carry reg to the cell.
//    - Shifts sum bit into the result MSB, shifts operands right, stores cell
//      carry, increments cnt.
//    - On the edge processing bit WIDTH-1: latch the cell carry-in as the
//      MSB carry-in, store the carry-out, go to DONE.
//  - DONE:
//    - res_valid_o=1; sum_o, cout_o and ovf_o are held constant.
//    - On res_valid_o & res_ready_i, go to IDLE.
//  - Latency: exactly WIDTH clocks from the accept edge to the first cycle with
//    res_valid_o=1. Throughput is one operation per WIDTH+2 cycles at best.
//  - start_ready_o=0 in RUN and DONE.
//    - start_valid_i in those states is ignored; it is neither accepted nor
//      queued.
//    - There is no same-cycle DONE->accept bypass.
//  - res_ready_i held 0 in DONE: the block stalls indefinitely and outputs stay
//    bit-stable.
//  - res_ready_i=1 outside DONE has no effect.
//  - Operand inputs are sampled only on the accept edge; later changes are
//    ignored.
//  - rst_i asserted in any state, including mid-RUN:
//    - Next state is IDLE with all reset values.
//    - The partial result is discarded; no res_valid_o pulse.
//  - Arithmetic is modulo 2^WIDTH.
//    - Add: {cout,sum} = A+B+cin.
//    - Sub: {cout,sum} = A+~B+1.
//  - cnt width is $clog2(WIDTH); the counter never wraps during RUN.
// STRUCTURE
//  - Shared package serial_arith_pkg holds:
//    - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t
//    - localparam int SA_MAX_WIDTH = 64
//  - One sub-module: a single instance of the existing full_adder cell (a_i,
//    b_i, cin_i, sum_o, cout_o).
//  - The FSM, counter, shift registers and carry register are all local to this
//    block.
// TESTING (WIDTH=8 unless stated)
//  1. Add 0x5A + 0x3C, cin=0 -> after 8 cycles sum=0x96, cout=0, ovf=1.
//  2. Add 0xFF + 0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add 0x7F+0x00, cin=1
//     -> sum=0x80, ovf=1.
//  3. Sub 0x10 - 0x20 -> sum=0xF0, cout=0, ovf=0. Sub 0x80 - 0x01 -> sum=0x7F,
//     cout=1, ovf=1.
//  4. Backpressure:
//     - Hold res_ready_i=0 for 5 cycles in DONE -> res_valid_o stays 1 and
//       sum_o is unchanged.
//     - start_valid_i=1 with new operands -> not accepted.
//  5. Assert rst_i for 1 cycle at RUN bit 3 -> next cycle IDLE, all outputs at
//     reset values, no res_valid_o; a fresh op then completes correctly.
//  6. Back-to-back ops with valid/ready always 1 -> accept edges spaced WIDTH+2
//     cycles apart. Repeat for WIDTH=2 with 0x3+0x1 -> sum=0x0, cout=1.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
//   sa_state_t   : sequencer state encoding (IDLE, RUN, DONE)
//   SA_MAX_WIDTH : largest supported operand width
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_MAX_WIDTH = 64;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// Signal suffixes are from the controller's point of view.
//   start_* : operand pair + mode handshake (producer -> controller)
//   res_*   : result handshake (controller -> consumer)
//   busy_o  : controller is in RUN or DONE
// Modports: master = producer/consumer side, slave = controller side.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start_valid_i;
  logic             start_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;
  logic             busy_o;

  modport master (
    output start_valid_i, a_i, b_i, cin_i, sub_i, res_ready_i,
    input  start_ready_o, res_valid_o, sum_o, cout_o, ovf_o, busy_o
  );

  modport slave (
    input  start_valid_i, a_i, b_i, cin_i, sub_i, res_ready_i,
    output start_ready_o, res_valid_o, sum_o, cout_o, ovf_o, busy_o
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a_i, b_i, cin_i : addend bits and carry in
//   sum_o, cout_o   : sum bit and carry out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer around one full_adder cell.
// Operands are accepted on the start handshake, walked LSB-first through the
// cell one bit per clock, and the sum/carry/overflow are held on the result
// handshake until consumed.
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, active-high
//   bus   : serial_add_ctrl_if.slave (start/result handshakes, busy)
module serial_add_ctrl
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  serial_add_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W    = $clog2(WIDTH);
  localparam int unsigned RES_W    = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if ((WIDTH < 2) || (WIDTH > SA_MAX_WIDTH)) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH out of range");
  end

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [RES_W-1:0] res_sh_q, res_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             start_ready_q, start_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  logic             fa_sum, fa_cout;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] res_full;

  assign accept   = (state_q == IDLE) && bus.start_valid_i;
  assign last_bit = (cnt_q == LAST_BIT);
  // New sum bit enters at the MSB; once all bits are in, this is the result.
  assign res_full = {fa_sum, res_sh_q};

  full_adder u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (bus.res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; handshake flags decode the next state.
  always_comb begin
    a_sh_d        = a_sh_q;
    b_sh_d        = b_sh_q;
    res_sh_d      = res_sh_q;
    cnt_d         = cnt_q;
    carry_d       = carry_q;
    sum_d         = sum_q;
    cout_d        = cout_q;
    ovf_d         = ovf_q;
    start_ready_d = (state_d == IDLE);
    res_valid_d   = (state_d == DONE);
    busy_d        = (state_d == RUN) || (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_sh_d  = bus.a_i;
          b_sh_d  = bus.sub_i ? ~bus.b_i : bus.b_i;
          carry_d = bus.sub_i ? 1'b1 : bus.cin_i;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_full[WIDTH-1:1];
        carry_d  = fa_cout;
        if (last_bit) begin
          sum_d  = res_full;
          cout_d = fa_cout;
          // carry_q is the carry into the MSB at this point.
          ovf_d  = carry_q ^ fa_cout;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      res_sh_q      <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      ovf_q         <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      a_sh_q        <= a_sh_d;
      b_sh_q        <= b_sh_d;
      res_sh_q      <= res_sh_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      sum_q         <= sum_d;
      cout_q        <= cout_d;
      ovf_q         <= ovf_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.start_ready_o = start_ready_q;
  assign bus.res_valid_o   = res_valid_q;
  assign bus.sum_o         = sum_q;
  assign bus.cout_o        = cout_q;
  assign bus.ovf_o         = ovf_q;
  assign bus.busy_o        = busy_q;

endmodule
